// File: rtl/floppy_step_monitor_pkg.sv
// Shared definitions for the floppy step/direction monitor: tracker states,
// track limits, direction encodings and the saturating head-position helper.
package floppy_step_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } mon_state_e;

  localparam int   FLOPPY_MAX_TRACK = 158;
  localparam logic DIR_REVERSE      = 1'b1;
  localparam logic DIR_FORWARD      = 1'b0;

  typedef struct packed {
    logic [7:0] pos;
    logic       limit;
  } pos_step_t;

  // One head step with saturation at track 0 and at max_track; limit flags a refused move.
  function automatic pos_step_t step_position(input logic [7:0] pos,
                                              input logic       dir,
                                              input logic [7:0] max_track);
    pos_step_t r;
    r.pos   = pos;
    r.limit = 1'b0;
    if (dir == DIR_REVERSE) begin
      if (pos == 8'd0) r.limit = 1'b1;
      else             r.pos   = pos - 8'd1;
    end else begin
      if (pos >= max_track) r.limit = 1'b1;
      else                  r.pos   = pos + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/floppy_step_monitor_if.sv
// Step/direction bus as seen by the monitor, plus the decoded status it reports.
// The master side is whoever drives the two wires; the slave side is the monitor.
interface floppy_step_monitor_if #(
  parameter int PERIOD_W = 16
);
  logic                step_in;
  logic                dir_in;
  logic [7:0]          position;
  logic                track0;
  logic                step_strobe;
  logic [PERIOD_W-1:0] step_period;
  logic                period_valid;
  logic                idle;
  logic                limit_err;

  modport master (
    output step_in, dir_in,
    input  position, track0, step_strobe, step_period, period_valid, idle, limit_err
  );

  modport slave (
    input  step_in, dir_in,
    output position, track0, step_strobe, step_period, period_valid, idle, limit_err
  );
endinterface

// File: rtl/floppy_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, followed by a
// both-edge detector on the synchronised level.
module floppy_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_98k,
  input  logic reset,
  input  logic d_in,
  output logic sync_out,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // SYNC_STAGES must be at least 2 for the shift slice below to be legal.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock_98k) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_out = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/floppy_step_monitor.sv
// Loop-back monitor for a floppy step/direction bus: tracks head position,
// flags limit violations and recovers the step period for comparison with the command.
module floppy_step_monitor
  import floppy_step_monitor_pkg::*;
#(
  parameter int MAX_TRACK   = FLOPPY_MAX_TRACK,
  parameter int PERIOD_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_98k,
  input  logic                  reset,
  floppy_step_monitor_if.slave  bus
);

  localparam logic [7:0]          MAX_POS = 8'(MAX_TRACK);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  logic step_event;
  logic step_level_unused;
  logic dir_sync;
  logic dir_edge_unused;

  floppy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clock_98k (clock_98k),
    .reset     (reset),
    .d_in      (bus.step_in),
    .sync_out  (step_level_unused),
    .edge_out  (step_event)
  );

  floppy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dir_sync (
    .clock_98k (clock_98k),
    .reset     (reset),
    .d_in      (bus.dir_in),
    .sync_out  (dir_sync),
    .edge_out  (dir_edge_unused)
  );

  mon_state_e          state_q, state_d;
  logic [7:0]          pos_q, pos_d;
  logic                track0_q, track0_d;
  logic                strobe_q, strobe_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                idle_q, idle_d;
  logic                err_q, err_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  pos_step_t           step_res;

  // An edge takes priority over a simultaneous counter timeout, so the interval
  // that just reached all-ones is still reported rather than discarded.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    period_d = period_q;
    err_d    = err_q;
    strobe_d = 1'b0;
    valid_d  = 1'b0;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    step_res = step_position(pos_q, dir_sync, MAX_POS);

    if (step_event) begin
      cnt_d    = '0;
      strobe_d = 1'b1;
      pos_d    = step_res.pos;
      if (step_res.limit) err_d = 1'b1;
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED, TRACK: begin
          state_d  = TRACK;
          period_d = cnt_q;
          valid_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == CNT_MAX) begin
      state_d  = IDLE;
      period_d = '0;
    end

    idle_d   = (state_d == IDLE);
    track0_d = (pos_d == 8'd0);
  end

  always_ff @(posedge clock_98k) begin
    if (!reset) begin
      state_q  <= IDLE;
      pos_q    <= 8'd0;
      track0_q <= 1'b1;
      strobe_q <= 1'b0;
      period_q <= '0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      track0_q <= track0_d;
      strobe_q <= strobe_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.position     = pos_q;
  assign bus.track0       = track0_q;
  assign bus.step_strobe  = strobe_q;
  assign bus.step_period  = period_q;
  assign bus.period_valid = valid_q;
  assign bus.idle         = idle_q;
  assign bus.limit_err    = err_q;

endmodule

// File: tb/tb_floppy_step_monitor.sv
// Directed bench for floppy_step_monitor: every driven step edge pushes its
// expected outcome to a queue that is popped when the DUT strobes.
module tb_floppy_step_monitor;
  import floppy_step_monitor_pkg::*;

  localparam int PERIOD_W  = 16;
  localparam int MAX_TRACK = 158;
  localparam int LATENCY   = 3;

  typedef struct {
    int   cyc;
    int   pos;
    logic t0;
    logic err;
    logic pv;
    int   period;
  } exp_t;

  logic clock_98k = 1'b0;
  logic reset     = 1'b0;
  int   cycle     = 0;
  int   checks    = 0;
  int   failures  = 0;
  exp_t sb[$];
  exp_t mon_e;

  int   m_pos, m_state, m_period, m_last;
  logic m_err;

  floppy_step_monitor_if #(.PERIOD_W(PERIOD_W)) bus ();

  floppy_step_monitor #(
    .MAX_TRACK   (MAX_TRACK),
    .PERIOD_W    (PERIOD_W),
    .SYNC_STAGES (2)
  ) dut (
    .clock_98k (clock_98k),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clock_98k = ~clock_98k;

  always @(posedge clock_98k) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock_98k);
    #1;
  endtask

  task automatic modelReset();
    m_pos    = 0;
    m_err    = 1'b0;
    m_state  = 0;
    m_period = 0;
    m_last   = cycle;
    sb.delete();
  endtask

  task automatic doReset(input int n);
    waitCycles(1);
    reset       = 1'b0;
    bus.step_in = 1'b0;
    bus.dir_in  = 1'b0;
    waitCycles(n);
    reset = 1'b1;
    modelReset();
  endtask

  // Toggle step after gap cycles and predict what the strobe cycle must show.
  task automatic applyStimulus(input int gap, input logic dir);
    exp_t e;
    int   n;
    waitCycles(gap);
    bus.dir_in  = dir;
    bus.step_in = ~bus.step_in;
    n      = cycle - m_last;
    m_last = cycle;
    if (m_state != 0 && n > 65536) begin
      m_state  = 0;
      m_period = 0;
    end
    e.pv = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      m_state  = 2;
      m_period = n - 1;
      e.pv     = 1'b1;
    end
    if (dir == DIR_REVERSE) begin
      if (m_pos == 0) m_err = 1'b1;
      else            m_pos = m_pos - 1;
    end else begin
      if (m_pos == MAX_TRACK) m_err = 1'b1;
      else                    m_pos = m_pos + 1;
    end
    e.cyc    = cycle + LATENCY;
    e.pos    = m_pos;
    e.t0     = (m_pos == 0);
    e.err    = m_err;
    e.period = m_period;
    sb.push_back(e);
  endtask

  always @(negedge clock_98k) begin
    if (reset === 1'b1) begin
      if (bus.period_valid === 1'b1 && bus.step_strobe !== 1'b1)
        checkOutput("valid_without_strobe", 32'(bus.step_strobe), 32'd1);
      if (bus.step_strobe === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_strobe", 32'(bus.step_strobe), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("strobe_cycle", cycle, mon_e.cyc);
          checkOutput("strobe_position", 32'(bus.position), mon_e.pos);
          checkOutput("strobe_track0", 32'(bus.track0), 32'(mon_e.t0));
          checkOutput("strobe_limit_err", 32'(bus.limit_err), 32'(mon_e.err));
          checkOutput("strobe_period_valid", 32'(bus.period_valid), 32'(mon_e.pv));
          checkOutput("strobe_step_period", 32'(bus.step_period), mon_e.period);
          checkOutput("strobe_idle", 32'(bus.idle), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.step_in = 1'b0;
    bus.dir_in  = 1'b0;
    reset       = 1'b0;

    waitCycles(4);
    checkOutput("rst_position", 32'(bus.position), 32'd0);
    checkOutput("rst_track0", 32'(bus.track0), 32'd1);
    checkOutput("rst_strobe", 32'(bus.step_strobe), 32'd0);
    checkOutput("rst_period", 32'(bus.step_period), 32'd0);
    checkOutput("rst_valid", 32'(bus.period_valid), 32'd0);
    checkOutput("rst_idle", 32'(bus.idle), 32'd1);
    checkOutput("rst_limit_err", 32'(bus.limit_err), 32'd0);
    reset = 1'b1;
    modelReset();

    waitCycles(100);
    checkOutput("quiet_position", 32'(bus.position), 32'd0);
    checkOutput("quiet_track0", 32'(bus.track0), 32'd1);
    checkOutput("quiet_idle", 32'(bus.idle), 32'd1);
    checkOutput("quiet_limit_err", 32'(bus.limit_err), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(101, DIR_FORWARD);
    waitCycles(10);
    checkOutput("fwd_drained", sb.size(), 32'd0);
    checkOutput("fwd_position", 32'(bus.position), 32'd5);
    checkOutput("fwd_period", 32'(bus.step_period), 32'd100);
    checkOutput("fwd_idle", 32'(bus.idle), 32'd0);

    doReset(2);
    for (int i = 0; i < 158; i++) applyStimulus(2, DIR_FORWARD);
    applyStimulus(2, DIR_FORWARD);
    waitCycles(10);
    checkOutput("top_drained", sb.size(), 32'd0);
    checkOutput("top_position", 32'(bus.position), 32'd158);
    checkOutput("top_limit_err", 32'(bus.limit_err), 32'd1);
    applyStimulus(5, DIR_REVERSE);
    waitCycles(10);
    checkOutput("top_back_position", 32'(bus.position), 32'd157);

    doReset(2);
    for (int i = 0; i < 3; i++) applyStimulus(1, DIR_FORWARD);
    for (int i = 0; i < 4; i++) applyStimulus(3, DIR_REVERSE);
    waitCycles(10);
    checkOutput("bottom_drained", sb.size(), 32'd0);
    checkOutput("bottom_position", 32'(bus.position), 32'd0);
    checkOutput("bottom_track0", 32'(bus.track0), 32'd1);
    checkOutput("bottom_limit_err", 32'(bus.limit_err), 32'd1);

    for (int i = 0; i < 3; i++) applyStimulus(101, DIR_FORWARD);
    waitCycles(10);
    checkOutput("track_drained", sb.size(), 32'd0);
    checkOutput("track_period", 32'(bus.step_period), 32'd100);
    waitCycles(65520);
    checkOutput("pre_timeout_idle", 32'(bus.idle), 32'd0);
    waitCycles(15);
    checkOutput("timeout_idle", 32'(bus.idle), 32'd1);
    checkOutput("timeout_period", 32'(bus.step_period), 32'd0);
    checkOutput("timeout_valid", 32'(bus.period_valid), 32'd0);
    applyStimulus(20, DIR_FORWARD);
    applyStimulus(50, DIR_FORWARD);
    for (int i = 0; i < 35; i++) applyStimulus(3, DIR_FORWARD);
    waitCycles(6);
    checkOutput("pre_reset_drained", sb.size(), 32'd0);
    checkOutput("pre_reset_position", 32'(bus.position), 32'd40);
    checkOutput("pre_reset_idle", 32'(bus.idle), 32'd0);

    waitCycles(3);
    bus.step_in = ~bus.step_in;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("midrst_position", 32'(bus.position), 32'd0);
    checkOutput("midrst_track0", 32'(bus.track0), 32'd1);
    checkOutput("midrst_idle", 32'(bus.idle), 32'd1);
    checkOutput("midrst_limit_err", 32'(bus.limit_err), 32'd0);
    checkOutput("midrst_period", 32'(bus.step_period), 32'd0);
    checkOutput("midrst_strobe", 32'(bus.step_strobe), 32'd0);
    reset = 1'b1;
    modelReset();
    waitCycles(10);
    checkOutput("post_rst_position", 32'(bus.position), 32'd0);
    applyStimulus(3, DIR_FORWARD);
    waitCycles(6);
    checkOutput("post_rst_drained", sb.size(), 32'd0);
    checkOutput("post_rst_step_position", 32'(bus.position), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/floppy_step_monitor.md
Name: floppy_step_monitor

Overview:
- Receive-side counterpart of the floppy step/direction drive interface; watches the two-wire bus (step, direction) that the drive controller puts on GPIO.
- Decodes step edges into a tracked head position, a track-0 flag and the recovered step period, so the value on the bus can be compared with the period that was commanded.
- Sits on the loop-back/monitor path next to each floppy channel and is clocked from clock_98k.

Parameters:
- MAX_TRACK, 158, highest legal head position; position saturates here.
- PERIOD_W, 16, width of the period counter and of step_period.
- SYNC_STAGES, 2, number of synchroniser flops on step_in and dir_in; minimum is 2.

Ports:
- clock_98k, input, 1, system clock.
- reset, input, 1, synchronous active-low reset; asserted when 0 at a clock_98k rising edge.
- step_in, input, 1, step line; every edge, rising or falling, is one step.
- dir_in, input, 1, direction line; 1 = toward track 0 (decrement), 0 = outward (increment).
- position, output, 8, current tracked head position, 0..MAX_TRACK.
- track0, output, 1, high when position == 0.
- step_strobe, output, 1, one-cycle pulse per accepted step edge.
- step_period, output, PERIOD_W, last recovered period; equals the commanded period value.
- period_valid, output, 1, one-cycle pulse when step_period updates.
- idle, output, 1, high when no step edge has been seen for 2^PERIOD_W - 1 cycles.
- limit_err, output, 1, sticky; set when a step is requested past 0 or past MAX_TRACK.

Behaviour:
- Reset values: position = 0, track0 = 1, step_strobe = 0, step_period = 0, period_valid = 0, idle = 1, limit_err = 0. Synchroniser flops, the edge-detect flop and the counter are also cleared. Reset wins over every other event in the same cycle.
- step_in and dir_in each pass through SYNC_STAGES flops. The edge detector compares the last synchronised step with a one-cycle-delayed copy; an XOR of the two is a step event.
- Latency from a step_in edge to step_strobe is SYNC_STAGES + 1 cycles. position updates on the same clock as step_strobe.
- Direction for each step is the synchronised dir value in the cycle the event is detected. The two lines share the same synchroniser depth, so a simultaneous dir/step change is applied together.
- Position arithmetic is 8-bit with saturation:
  - dir = 1 and position = 0: position holds and limit_err is set.
  - dir = 0 and position = MAX_TRACK: position holds and limit_err is set.
  - step_strobe still pulses in both limit cases.
- track0 is registered and follows position in the same cycle.
- Period counter cnt is PERIOD_W bits. It increments every cycle and saturates at all-ones. It clears to 0 on each step event.
- State machine:
  - IDLE: waiting for an edge. On an edge, go to ARMED; no period is reported because the interval is unknown.
  - ARMED: one edge seen. On the next edge, set step_period = cnt, pulse period_valid and go to TRACK.
  - TRACK: on each edge, set step_period = cnt and pulse period_valid.
  - From ARMED or TRACK, if cnt reaches all-ones, go to IDLE, set idle = 1 and step_period = 0.
- idle is 0 in ARMED and TRACK.
- Period rule: an edge interval of N cycles gives step_period = N - 1, matching the driver's tick compare, so a commanded period P reads back as P. Minimum interval is 1 cycle, which gives step_period = 0.
- Edges arriving faster than the synchroniser can resolve are not this block's concern; consecutive-cycle edges are each counted.
- limit_err clears only on reset.

Decomposition:
- Shared floppy package holds:
  - the state enum: IDLE, ARMED, TRACK;
  - constant FLOPPY_MAX_TRACK = 158;
  - direction encodings DIR_REVERSE = 1, DIR_FORWARD = 0.
- One natural sub-module: floppy_sync_edge. It holds the parameterised synchroniser and the both-edge detector, and is instantiated once for step. The dir path uses the same synchroniser with the edge output left unused.

Test Plan:
- Reset, then hold step_in and dir_in at 0 for 100 cycles: position = 0, track0 = 1, idle = 1, no strobes, limit_err = 0.
- dir = 0, toggle step every 101 cycles for 5 edges:
  - position reaches 5 and track0 drops after the first strobe;
  - first period_valid comes on the 2nd edge with step_period = 100, then 100 on each later edge;
  - each strobe lands 3 cycles after its edge.
- Preset position to 158 with 158 edges, then one more edge with dir = 0: position stays 158, limit_err = 1, step_strobe still pulses. Reverse with dir = 1 for one edge: position = 157.
- From position 3, dir = 1, 4 edges: position goes 2, 1, 0, 0; track0 = 1; limit_err = 1.
- After TRACK with period 100, stop toggling for 65535 cycles: idle = 1, step_period = 0. The next edge produces no period_valid and the one after reports the new interval.
- Drop reset to 0 mid-run at position 40 in TRACK: next cycle position = 0, idle = 1, limit_err = 0, step_period = 0. An edge in the same cycle as reset is ignored.
